// File: rtl/button_event_decoder_pkg.sv
// Shared types and constants for the debounced-button event decoder.
package button_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_PRESSED
    } state_t;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_NONE   = 2'b00;
    localparam evt_code_t EVT_SHORT  = 2'b01;
    localparam evt_code_t EVT_LONG   = 2'b10;
    localparam evt_code_t EVT_DOUBLE = 2'b11;

    // Counter must hold the larger of the two thresholds.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/button_event_decoder_slot.sv
// Single-entry event holding register with valid/ready handoff and sticky overflow.
module btn_evt_slot
    import button_evt_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  evt_code_t code,
    input  logic      ready,
    input  logic      ovf_clr,
    output logic      evt_valid,
    output evt_code_t evt_code,
    output logic      overflow
);

    logic accept;
    logic load;

    assign accept = evt_valid & ready;
    // An accept in the same cycle frees the slot, so the new event replaces the old one.
    assign load   = push & (~evt_valid | ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_code  <= EVT_NONE;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_code  <= code;
        end else if (accept) begin
            evt_valid <= 1'b0;
            evt_code  <= EVT_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && !load) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (evt_valid && !ready) |=> (evt_valid && $stable(evt_code)));

    a_idle_code : assert property (@(posedge clk) disable iff (!rst_n)
        !evt_valid |-> (evt_code == EVT_NONE));

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced presses into SHORT / LONG / DOUBLE events for a valid/ready consumer.
module button_event_decoder
    import button_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       db_in,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       hold_active,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             db_prev;
    logic             rise;
    logic             push;
    evt_code_t        push_code;

    assign rise    = db_in & ~db_prev;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // db_prev resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            db_prev <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            db_prev <= db_in;
        end
    end

    // Thresholds test the incremented count so the rise cycle counts as the first
    // high (or first released) cycle of the interval being measured.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push      = 1'b0;
        push_code = EVT_NONE;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                cnt_nxt = cnt_inc;
                if (!db_in) begin
                    state_nxt = WAIT_GAP;
                    cnt_nxt   = '0;
                end else if (cnt_inc == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                    push      = 1'b1;
                    push_code = EVT_LONG;
                end
            end
            LONG_HELD: begin
                if (!db_in) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_GAP: begin
                cnt_nxt = cnt_inc;
                if (db_in) begin
                    state_nxt = SECOND_PRESSED;
                    push      = 1'b1;
                    push_code = EVT_DOUBLE;
                end else if (cnt_inc == GAP_LAST) begin
                    state_nxt = IDLE;
                    push      = 1'b1;
                    push_code = EVT_SHORT;
                end
            end
            SECOND_PRESSED: begin
                if (!db_in) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign hold_active = (state == LONG_HELD);

    btn_evt_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .code      (push_code),
        .ready     (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor checks each accept.
module tb_button_event_decoder;
    import button_evt_pkg::*;

    localparam int unsigned LC = 8;
    localparam int unsigned GC = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       db_in = 1'b0;
    logic       evt_ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       hold_active;
    logic       overflow;

    button_event_decoder #(.LONG_CYCLES(LC), .GAP_CYCLES(GC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .db_in       (db_in),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .hold_active (hold_active),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        logic [1:0] code;
        int         at_edge;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        db_in = v;
        tick(n);
    endtask

    task automatic expect_evt(input logic [1:0] c, input int at);
        exp_t e;
        e.code    = c;
        e.at_edge = at;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: an accept happens at the next posedge whenever valid&ready here.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual=%0h required=none at_edge=%0d", evt_code, ecnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (evt_code !== e.code) begin
                    errors++;
                    $display("FAIL evt_code actual=%0h required=%0h at_edge=%0d", evt_code, e.code, ecnt);
                end
                if (e.at_edge >= 0) begin
                    checks++;
                    if (ecnt != e.at_edge) begin
                        errors++;
                        $display("FAIL evt_timing actual_edge=%0d required_edge=%0d", ecnt, e.at_edge);
                    end
                end
            end
        end
    end

    initial begin
        int b;
        int guard;

        tick(2);
        chk("reset_valid", {1'b0, evt_valid}, 2'b00);
        chk("reset_code", evt_code, EVT_NONE);
        chk("reset_hold", {1'b0, hold_active}, 2'b00);
        chk("reset_ovf", {1'b0, overflow}, 2'b00);
        rst_n = 1'b1;
        tick(2);

        // Short press: 3 high, 5 low -> SHORT on 8th edge.
        b = ecnt;
        expect_evt(EVT_SHORT, b + 8);
        drive(1'b1, 3);
        chk("short_hold_during", {1'b0, hold_active}, 2'b00);
        drive(1'b0, 5);
        drive(1'b0, 6);
        chk("short_hold_after", {1'b0, hold_active}, 2'b00);

        // Long press: 8 high -> LONG on 8th edge, hold_active until release.
        b = ecnt;
        expect_evt(EVT_LONG, b + 8);
        drive(1'b1, 7);
        chk("long_hold_pre", {1'b0, hold_active}, 2'b00);
        drive(1'b1, 1);
        chk("long_hold_on", {1'b0, hold_active}, 2'b01);
        drive(1'b1, 4);
        chk("long_hold_still", {1'b0, hold_active}, 2'b01);
        drive(1'b0, 1);
        chk("long_hold_off", {1'b0, hold_active}, 2'b00);
        drive(1'b0, 10);

        // 7 high cycles is one short of LONG -> SHORT after the gap.
        b = ecnt;
        expect_evt(EVT_SHORT, b + 12);
        drive(1'b1, 7);
        drive(1'b0, 10);

        // Double: 3 high, 2 low, 3 high -> DOUBLE at the second rise.
        b = ecnt;
        expect_evt(EVT_DOUBLE, b + 6);
        drive(1'b1, 3);
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 10);

        // Second press on the timeout cycle wins -> DOUBLE.
        b = ecnt;
        expect_evt(EVT_DOUBLE, b + 8);
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 3);
        drive(1'b0, 10);

        // Press one cycle after the timeout -> SHORT then a fresh SHORT.
        b = ecnt;
        expect_evt(EVT_SHORT, b + 8);
        expect_evt(EVT_SHORT, b + 16);
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b1, 3);
        drive(1'b0, 10);
        chk("no_ovf_yet", {1'b0, overflow}, 2'b00);

        // Back-pressure: SHORT pending, LONG dropped, overflow sticky.
        evt_ready = 1'b0;
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b0, 2);
        chk("bp_valid", {1'b0, evt_valid}, 2'b01);
        chk("bp_code", evt_code, EVT_SHORT);
        drive(1'b1, 8);
        drive(1'b0, 1);
        chk("bp_ovf_set", {1'b0, overflow}, 2'b01);
        chk("bp_code_held", evt_code, EVT_SHORT);
        drive(1'b0, 3);
        expect_evt(EVT_SHORT, -1);
        evt_ready = 1'b1;
        tick(1);
        chk("bp_valid_cleared", {1'b0, evt_valid}, 2'b00);
        chk("bp_code_cleared", evt_code, EVT_NONE);
        chk("bp_ovf_sticky", {1'b0, overflow}, 2'b01);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", {1'b0, overflow}, 2'b00);
        tick(3);

        // Button held through reset is ignored until released and pressed again.
        db_in = 1'b1;
        rst_n = 1'b0;
        tick(2);
        chk("rst2_valid", {1'b0, evt_valid}, 2'b00);
        chk("rst2_hold", {1'b0, hold_active}, 2'b00);
        rst_n = 1'b1;
        drive(1'b1, 20);
        drive(1'b0, 10);
        b = ecnt;
        expect_evt(EVT_SHORT, b + 8);
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b0, 3);

        // Async reset in WAIT_GAP with an event pending clears everything at once.
        evt_ready = 1'b0;
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("pre_rst_valid", {1'b0, evt_valid}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {1'b0, evt_valid}, 2'b00);
        chk("async_rst_code", evt_code, EVT_NONE);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL async_rst_state actual=%0d required=%0d", int'(dut.state), int'(IDLE));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        evt_ready = 1'b1;
        drive(1'b0, 10);

        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            tick(1);
            guard++;
        end
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event actual=none required=%0h at_edge=%0d", e.code, e.at_edge);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the debouncer FSM and consumes its clean level output (debouncer_out → db_in).
- Classifies each debounced press into SHORT, LONG or DOUBLE events using an internal cycle counter.
- Delivers one event at a time to a consumer (UI/CSR logic) over a valid/ready handshake, with a sticky overflow flag for dropped events.

Parameters:
- LONG_CYCLES, 50_000_000: cycles db_in must stay high to qualify as a long press; must be ≥2.
- GAP_CYCLES, 12_500_000: maximum released cycles after a short press in which a second press makes a DOUBLE; must be ≥2.
- CNT_W, $clog2(max(LONG_CYCLES,GAP_CYCLES))+1: internal counter width (localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- db_in  in  1  debounced button level, synchronous to clk.
- evt_valid  out  1  event pending.
- evt_code  out  2  01=SHORT, 10=LONG, 11=DOUBLE; 00 when evt_valid=0.
- evt_ready  in  1  consumer accepts the event when evt_valid&evt_ready at a posedge.
- hold_active  out  1  high while in LONG_HELD.
- overflow  out  1  sticky; set when an event is generated while a previous one is still pending.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset: state=IDLE, cnt=0, db_prev=1, evt_valid=0, evt_code=00, hold_active=0, overflow=0. Because db_prev=1, a button held through reset is ignored until it is released and pressed again.
- Rise = db_in & ~db_prev. db_prev is registered every cycle.
- IDLE: on rise → PRESSED, cnt←0.
- PRESSED: cnt increments each cycle.
  - db_in=0 → WAIT_GAP, cnt←0.
  - Else, if cnt==LONG_CYCLES-1 → LONG_HELD and generate LONG. db_in high for exactly LONG_CYCLES cycles yields LONG.
- LONG_HELD: hold_active=1. db_in=0 → IDLE. No SHORT is ever generated for this press.
- WAIT_GAP: cnt increments each cycle.
  - db_in=1 → SECOND_PRESSED and generate DOUBLE.
  - Else, if cnt==GAP_CYCLES-1 → IDLE and generate SHORT.
  - db_in=1 in the timeout cycle: the press wins, giving DOUBLE.
- SECOND_PRESSED: no long-press detection. db_in=0 → IDLE. A third press starts a fresh sequence from IDLE.
- Event generation:
  - Registered; evt_valid/evt_code update on the same edge as the state transition, so they are visible in the first cycle of the new state.
  - If evt_valid=0, or evt_valid&evt_ready in that cycle, the new event is loaded. Same-cycle accept plus new event means the new event replaces the old with no bubble and no overflow.
  - Otherwise the new event is dropped, the pending event is held unchanged, and overflow←1.
- Accept with no new event → evt_valid←0, evt_code←00.
- evt_valid never deasserts without a handshake; evt_code is stable while evt_valid=1.
- ovf_clr clears overflow. If ovf_clr coincides with a new overflow, the set wins.
- Counter saturates at its terminal value. It never wraps, because it is cleared on every state entry that uses it.
- Async reset mid-operation returns everything to reset values immediately. Any pending event is lost.

Decomposition:
- Package button_evt_pkg:
  - state enum: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_PRESSED.
  - event code constants: EVT_NONE=00, EVT_SHORT=01, EVT_LONG=10, EVT_DOUBLE=11.
- One sub-module, btn_evt_slot: the single-entry output holding register.
  - Inputs: push, code, ready, ovf_clr.
  - Outputs: evt_valid, evt_code, overflow.
  - Keeps the handshake/overflow logic separate from the classifier FSM.

Test Plan (LONG_CYCLES=8, GAP_CYCLES=5, evt_ready=1 unless stated):
- db_in high 3 cycles, then low 5 cycles → one evt_code=01 pulse on the 5th low-cycle edge; hold_active never asserts.
- db_in high 8 cycles → evt_code=10 at the 8th edge; hold_active=1 until db_in falls; no SHORT after release.
- High 3, low 2, high 3, low → exactly one evt_code=11 on the second rise, then no further events.
- High 3, low 4, db_in rises exactly on the timeout cycle → DOUBLE (11), not SHORT.
- evt_ready=0: short press then long press → evt_code stays 01, overflow=1; raise evt_ready → one accept, evt_valid=0; pulse ovf_clr → overflow=0.
- db_in=1 through reset release, held 20 cycles, then low 10 cycles → no event; a subsequent short press → SHORT. Assert rst_n low during WAIT_GAP → evt_valid=0 and state IDLE immediately.
